// File: rtl/dram_responder.sv
// Responder end of the shared DRAM bus: on-chip word memory behind a fixed-latency
// handshake, with byte/half/word lane steering and load sign/zero extension.
module dram_responder #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] BASE      = 32'h80000000,
  parameter int          LATENCY   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  input  logic        dram_we_t,
  input  logic        dram_le,
  input  logic [2:0]  dram_ctrl,
  output logic [31:0] dram_odata,
  output logic        dram_busy,
  output logic        dram_err
);
  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_ctrl;
  logic        r_ld, r_st;
  logic        r_busy, r_err;
  logic [31:0] r_odata;
  logic [31:0] r_mem [MEM_WORDS];

  logic          w_accept;
  logic [31:0]   w_off;
  logic [29:0]   w_widx;
  logic [IW-1:0] w_idx;
  logic [1:0]    w_size;
  logic          w_oob, w_illegal, w_misal, w_fault, w_err;
  logic [31:0]   w_word, w_ld, w_wrep;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [3:0]    w_be;
  logic          w_unused;

  assign w_accept = (r_state == S_IDLE) && (dram_le || dram_we_t);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 8'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Decode is done on the latched request so the bus may change freely while busy.
  assign w_off     = r_addr - BASE;
  assign w_widx    = w_off[31:2];
  assign w_idx     = w_widx[IW-1:0];
  assign w_unused  = ^w_off[1:0];
  assign w_size    = r_ctrl[1:0];
  assign w_oob     = w_widx >= 30'(MEM_WORDS);
  assign w_illegal = (r_ctrl == 3'd3) || (r_ctrl == 3'd6) || (r_ctrl == 3'd7);
  assign w_misal   = ((w_size == 2'd1) && r_addr[0]) ||
                     ((w_size == 2'd2) && (r_addr[1:0] != 2'd0));
  assign w_fault   = w_oob || w_illegal || w_misal;
  assign w_err     = w_fault || (r_ld && r_st);

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ld = 32'd0;
    case (r_ctrl)
      3'd0:    w_ld = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ld = {{16{w_half[15]}}, w_half};
      3'd2:    w_ld = w_word;
      3'd4:    w_ld = {24'd0, w_byte};
      3'd5:    w_ld = {16'd0, w_half};
      default: w_ld = 32'd0;
    endcase
  end

  always_comb begin
    w_be   = 4'hF;
    w_wrep = r_wdata;
    case (w_size)
      2'd0: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wrep = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be   = 4'b0011 << {r_addr[1], 1'b0};
        w_wrep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'hF;
        w_wrep = r_wdata;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_addr  <= dram_addr;
      r_wdata <= dram_wdata;
      r_ctrl  <= dram_ctrl;
      r_ld    <= dram_le;
      r_st    <= dram_we_t;
    end
  end

  // The load result is captured on the WAIT->DONE edge so it is valid as busy drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= 8'd0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_odata <= 32'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt  <= 8'(LATENCY - 1);
          r_busy <= 1'b1;
        end
        S_WAIT: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
          else begin
            r_busy <= 1'b0;
            r_err  <= w_err;
            if (r_ld && !r_st) r_odata <= w_fault ? 32'd0 : w_ld;
          end
        end
        default: ;
      endcase
    end
  end

  // Store commits in DONE, so a following load can never see stale data.
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == S_DONE) && r_st && !r_ld && !w_fault) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
    end
  end

  assign dram_busy  = r_busy;
  assign dram_err   = r_err;
  assign dram_odata = r_odata;
endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: scoreboard of expected completions, checked as busy drops.
module tb_dram_responder;
  localparam int          MEM_WORDS = 16384;
  localparam logic [31:0] BASE      = 32'h80000000;
  localparam int          LATENCY   = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] dram_addr = 32'd0, dram_wdata = 32'd0;
  logic        dram_we_t = 1'b0, dram_le = 1'b0;
  logic [2:0]  dram_ctrl = 3'd0;
  logic [31:0] dram_odata;
  logic        dram_busy, dram_err;

  typedef struct {
    logic [31:0] od;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_od = 32'd0;

  dram_responder #(.MEM_WORDS(MEM_WORDS), .BASE(BASE), .LATENCY(LATENCY)) dut (
    .CLK(CLK), .RST(RST), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_we_t(dram_we_t), .dram_le(dram_le), .dram_ctrl(dram_ctrl),
    .dram_odata(dram_odata), .dram_busy(dram_busy), .dram_err(dram_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: strobe for one cycle, count busy cycles, compare completion to scoreboard.
  // upd_od: a successful or faulted load that replaces odata; otherwise odata must hold.
  task automatic acc(input string tag, input logic le, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] ctrl,
                     input logic [31:0] od, input logic err, input bit upd_od, input bit poke);
    exp_t e;
    int   n;
    e.od  = upd_od ? od : last_od;
    e.err = err;
    e.tag = tag;
    @(negedge CLK);
    dram_le = le; dram_we_t = we; dram_addr = addr; dram_wdata = wdata; dram_ctrl = ctrl;
    sb.push_back(e);
    @(negedge CLK);
    dram_le = 1'b0; dram_we_t = 1'b0;
    n = 0;
    while (dram_busy === 1'b1 && n < 300) begin
      n++;
      if (poke && n == 2) begin
        dram_we_t = 1'b1; dram_addr = BASE; dram_wdata = 32'h0; dram_ctrl = 3'd2;
      end
      @(negedge CLK);
      dram_we_t = 1'b0;
    end
    check({tag, " busy_len"}, 32'(n), 32'(LATENCY));
    e = sb.pop_front();
    check({e.tag, " err"}, {31'd0, dram_err}, {31'd0, e.err});
    check({e.tag, " odata"}, dram_odata, e.od);
    last_od = e.od;
    @(negedge CLK);
    check({tag, " err_pulse"}, {31'd0, dram_err}, 32'd0);
    check({tag, " idle"}, {31'd0, dram_busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset busy", {31'd0, dram_busy}, 32'd0);
    check("reset odata", dram_odata, 32'd0);
    check("reset err", {31'd0, dram_err}, 32'd0);

    acc("SW base", 0, 1, BASE, 32'h11223344, 3'd2, 32'h0, 0, 0, 0);
    acc("LW base", 1, 0, BASE, 32'h0, 3'd2, 32'h11223344, 0, 1, 0);
    acc("SW +8", 0, 1, BASE + 8, 32'hDEADBEEF, 3'd2, 32'h0, 0, 0, 0);
    acc("LW +8", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEADBEEF, 0, 1, 0);
    acc("SB +9", 0, 1, BASE + 9, 32'h00000080, 3'd0, 32'h0, 0, 0, 0);
    acc("LB +9", 1, 0, BASE + 9, 32'h0, 3'd0, 32'hFFFFFF80, 0, 1, 0);
    acc("LBU +9", 1, 0, BASE + 9, 32'h0, 3'd4, 32'h00000080, 0, 1, 0);
    acc("LW +8 merged", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEAD80EF, 0, 1, 0);
    acc("LH +10", 1, 0, BASE + 10, 32'h0, 3'd1, 32'hFFFFDEAD, 0, 1, 0);
    acc("LHU +10", 1, 0, BASE + 10, 32'h0, 3'd5, 32'h0000DEAD, 0, 1, 0);
    acc("SH +8", 0, 1, BASE + 8, 32'hABCD1234, 3'd1, 32'h0, 0, 0, 0);
    acc("LW +8 half", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEAD1234, 0, 1, 0);

    acc("LH misal", 1, 0, BASE + 3, 32'h0, 3'd1, 32'h0, 1, 1, 0);
    acc("SW oob", 0, 1, BASE + MEM_WORDS * 4, 32'hCAFEF00D, 3'd2, 32'h0, 1, 0, 0);
    acc("LW word0", 1, 0, BASE, 32'h0, 3'd2, 32'h11223344, 0, 1, 0);
    acc("LW misal", 1, 0, BASE + 2, 32'h0, 3'd2, 32'h0, 1, 1, 0);
    acc("LW +8 again", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEAD1234, 0, 1, 0);
    acc("ctrl illegal", 1, 0, BASE, 32'h0, 3'd3, 32'h0, 1, 1, 0);
    acc("LW +8 refill", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEAD1234, 0, 1, 0);
    acc("le+we", 1, 1, BASE, 32'hFFFFFFFF, 3'd2, 32'h0, 1, 0, 0);
    acc("LW base nowr", 1, 0, BASE, 32'h0, 3'd2, 32'h11223344, 0, 1, 0);
    acc("poke busy", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEAD1234, 0, 1, 1);
    acc("LW base nopoke", 1, 0, BASE, 32'h0, 3'd2, 32'h11223344, 0, 1, 0);

    // Reset in the middle of a store: aborted, busy drops, memory keeps old word.
    @(negedge CLK);
    dram_we_t = 1'b1; dram_addr = BASE + 8; dram_wdata = 32'h55555555; dram_ctrl = 3'd2;
    @(negedge CLK);
    dram_we_t = 1'b0;
    check("abort busy before", {31'd0, dram_busy}, 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort busy", {31'd0, dram_busy}, 32'd0);
    check("abort odata", dram_odata, 32'd0);
    check("abort err", {31'd0, dram_err}, 32'd0);
    RST = 1'b0;
    last_od = 32'd0;
    repeat (LATENCY + 2) @(negedge CLK);
    check("abort stays idle", {31'd0, dram_busy}, 32'd0);
    acc("LW after abort", 1, 0, BASE + 8, 32'h0, 3'd2, 32'hDEAD1234, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
